dual_lane_mem_scheduler: RTL and testbench
==========================================

Name: dual_lane_mem_scheduler

Overview:
- Shares the single data-memory port between the two issue lanes of the MEM stage.
- When both lanes access memory in the same cycle, serializes them in program order: lane 0 first, lane 1 second.
- Stalls the pipeline for the extra cycle and returns load data to both lanes together.
- Sits between the MEM-stage pipeline register outputs and the Memory block; provides the stall term consumed by the hazard unit.

Parameters:
WIDTH, 32, data/address width
CNT_W, 16, width of saturating conflict counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rd_en_MEM  in  2  per-lane load request, bit i = lane i
wr_en_MEM  in  2  per-lane store request
addr_MEM  in  2xWIDTH  per-lane byte address (ALU result)
wdata_MEM  in  2xWIDTH  per-lane store data
kill_lane1  in  1  cancel lane 1's memory op (older lane faulted/redirected)
mem_read_en  out  1  to Memory read enable
mem_write_en  out  1  to Memory write enable
mem_address  out  WIDTH  to Memory address
mem_write_data  out  WIDTH  to Memory write data
mem_read_data  in  WIDTH  from Memory, combinational read
lane_rdata  out  2xWIDTH  load result per lane, valid when stall_MEM=0
stall_MEM  out  1  hold F/DE/EX/MEM pipeline registers this cycle
conflict_cnt  out  CNT_W  saturating count of serialized pairs

Behaviour:
- Lane request: active = rd_en|wr_en. If both bits are set, the access is a write; the read is ignored.
- States:
  - IDLE (reset)
  - SECOND (lane 1 pending)
- IDLE, no lane active:
  - mem_read_en=0, mem_write_en=0, address/data=0.
  - stall_MEM=0, lane_rdata=0.
- IDLE, exactly one lane active:
  - That lane's request is passed combinationally to the memory port.
  - lane_rdata[i]=mem_read_data; the other lane's data=0.
  - stall_MEM=0. Stay in IDLE. Zero added latency.
- IDLE, both lanes active:
  - Drive lane 0 to memory; stall_MEM=1.
  - At the clock edge:
    - hold0 <= mem_read_data;
    - pend <= lane 1 request (rd, wr, addr, wdata);
    - conflict_cnt += 1, saturating at all-ones.
  - Go to SECOND.
- SECOND:
  - Drive pend to memory; stall_MEM=0.
  - lane_rdata[0]=hold0; lane_rdata[1]=mem_read_data.
  - Return to IDLE. Lane inputs are ignored this cycle because the pipeline held them stable.
  - Total cost of a conflict: exactly 1 bubble cycle.
- kill_lane1:
  - In SECOND: memory enables forced to 0, lane_rdata[1]=0, return to IDLE, stall_MEM=0.
  - In IDLE: lane 1's request is masked, so the pair is not a conflict and no stall occurs.
- Ordering guarantees:
  - Lane 0 store followed by lane 1 load to the same address: the store commits at the IDLE→SECOND edge, so the load reads the new value.
  - Both lanes store to the same address: lane 1's value is final.
- Reset (rst=0, asynchronous):
  - state=IDLE; hold0, pend and conflict_cnt cleared.
  - All outputs are 0 during reset, including stall_MEM and the memory enables.
  - Reset while in SECOND abandons the pending access with no memory write.
- No combinational path from mem_read_data to stall_MEM.

Decomposition:
- superscalar_pkg:
  - LANES=2.
  - typedef enum sched_state_t {IDLE, SECOND}.
  - typedef struct mem_req_t {rd, wr, addr, wdata}.
- One sub-module, mem_req_mux: combinational selection of the active mem_req_t onto the memory port.
- FSM, hold and pending registers, and counter live in the top.

Test Plan:
- Lane 0 load from 0x100 (mem=0xDEADBEEF), lane 1 idle -> same cycle: mem_address=0x100, lane_rdata[0]=0xDEADBEEF, stall_MEM=0.
- Lane 0 load 0x100 (0x11), lane 1 load 0x104 (0x22) -> cycle N: stall_MEM=1, address 0x100; cycle N+1: address 0x104, lane_rdata={0x22,0x11}, conflict_cnt=1.
- Lane 0 store 0x55 to 0x200, lane 1 load 0x200 -> N+1 lane_rdata[1]=0x55, one write pulse only, in cycle N.
- Both lanes store to 0x300 (0xA, 0xB) -> later read of 0x300 returns 0xB; two write pulses in consecutive cycles.
- Conflict pair with kill_lane1 asserted in cycle N+1 -> no memory enable in N+1, lane_rdata[1]=0, state returns to IDLE; rst pulse low in SECOND -> all outputs 0 immediately, counter 0, no write.
- Force 2^CNT_W+3 conflicting pairs -> conflict_cnt holds at all-ones.

Source files
------------

// File: rtl/superscalar_pkg.sv
// Shared types for the dual-lane MEM stage: scheduler states, memory request
// bundle and the port-select code used by the request mux.
package superscalar_pkg;

    localparam int LANES  = 2;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE,
        SECOND
    } sched_state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LANE0,
        SEL_LANE1,
        SEL_PEND
    } req_sel_t;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // A lane asserting both enables performs a store; its read is dropped.
    function automatic mem_req_t make_req(
        input logic              rd,
        input logic              wr,
        input logic [DATA_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        mem_req_t req;
        req.rd    = rd & ~wr;
        req.wr    = wr;
        req.addr  = addr;
        req.wdata = wdata;
        return req;
    endfunction

endpackage

// File: rtl/mem_req_mux.sv
// Steers one of the candidate memory requests onto the single memory port;
// SEL_NONE drives an all-zero, disabled port.
module mem_req_mux
    import superscalar_pkg::*;
(
    input  req_sel_t          sel,
    input  mem_req_t          lane0_req,
    input  mem_req_t          lane1_req,
    input  mem_req_t          pend_req,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data
);

    mem_req_t sel_req;

    always_comb begin
        sel_req = '0;
        case (sel)
            SEL_LANE0: sel_req = lane0_req;
            SEL_LANE1: sel_req = lane1_req;
            SEL_PEND:  sel_req = pend_req;
            default:   sel_req = '0;
        endcase
    end

    assign mem_read_en    = sel_req.rd;
    assign mem_write_en   = sel_req.wr;
    assign mem_address    = sel_req.addr;
    assign mem_write_data = sel_req.wdata;

endmodule

// File: rtl/dual_lane_mem_scheduler.sv
// Arbitrates the single data-memory port between two MEM-stage lanes,
// serialising same-cycle accesses (lane 0 then lane 1) with a one-cycle stall.
module dual_lane_mem_scheduler
    import superscalar_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            rd_en_MEM,
    input  logic [LANES-1:0]            wr_en_MEM,
    input  logic [LANES-1:0][WIDTH-1:0] addr_MEM,
    input  logic [LANES-1:0][WIDTH-1:0] wdata_MEM,
    input  logic                        kill_lane1,
    output logic                        mem_read_en,
    output logic                        mem_write_en,
    output logic [WIDTH-1:0]            mem_address,
    output logic [WIDTH-1:0]            mem_write_data,
    input  logic [WIDTH-1:0]            mem_read_data,
    output logic [LANES-1:0][WIDTH-1:0] lane_rdata,
    output logic                        stall_MEM,
    output logic [CNT_W-1:0]            conflict_cnt
);

    mem_req_t        lane_req [LANES];
    logic [LANES-1:0] lane_act;
    logic [LANES-1:0] lane_live;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_req[gi] = make_req(rd_en_MEM[gi], wr_en_MEM[gi],
                                       addr_MEM[gi], wdata_MEM[gi]);
        assign lane_act[gi] = rd_en_MEM[gi] | wr_en_MEM[gi];
    end

    // A killed lane 1 never competes for the port, so it cannot cause a stall.
    assign lane_live = {lane_act[1] & ~kill_lane1, lane_act[0]};

    sched_state_t state_q, state_d;
    logic [WIDTH-1:0] hold0_q, hold0_d;
    mem_req_t         pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    req_sel_t                    sel;
    logic                        stall;
    logic [LANES-1:0][WIDTH-1:0] rdata;

    always_comb begin
        state_d = state_q;
        hold0_d = hold0_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        sel     = SEL_NONE;
        stall   = 1'b0;
        rdata   = '0;
        case (state_q)
            IDLE: begin
                case (lane_live)
                    2'b01: begin
                        sel      = SEL_LANE0;
                        rdata[0] = mem_read_data;
                    end
                    2'b10: begin
                        sel      = SEL_LANE1;
                        rdata[1] = mem_read_data;
                    end
                    2'b11: begin
                        sel     = SEL_LANE0;
                        stall   = 1'b1;
                        hold0_d = mem_read_data;
                        pend_d  = lane_req[1];
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        state_d = SECOND;
                    end
                    default: ;
                endcase
            end
            SECOND: begin
                state_d  = IDLE;
                rdata[0] = hold0_q;
                if (!kill_lane1) begin
                    sel      = SEL_PEND;
                    rdata[1] = mem_read_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold0_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold0_q <= hold0_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced quiet while reset is held so no write can escape.
    mem_req_mux u_mux (
        .sel            (rst ? sel : SEL_NONE),
        .lane0_req      (lane_req[0]),
        .lane1_req      (lane_req[1]),
        .pend_req       (pend_q),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data)
    );

    assign stall_MEM    = rst & stall;
    assign lane_rdata   = rst ? rdata : '0;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dual_lane_mem_scheduler.sv
// Directed plus random bench for dual_lane_mem_scheduler against a
// transaction-level model of memory contents, port usage and conflict count.
module tb_dual_lane_mem_scheduler;

    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]        rd_en_MEM, wr_en_MEM;
    logic [1:0][W-1:0] addr_MEM, wdata_MEM;
    logic              kill_lane1;
    logic              mem_read_en, mem_write_en;
    logic [W-1:0]      mem_address, mem_write_data, mem_read_data;
    logic [1:0][W-1:0] lane_rdata;
    logic              stall_MEM;
    logic [CW-1:0]     conflict_cnt;

    logic [W-1:0] tb_mem  [256];
    logic [W-1:0] ref_mem [256];
    int wr_pulses = 0;
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int ref_cnt = 0;
    int txn = 0;

    always #5 clk = ~clk;

    dual_lane_mem_scheduler #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en_MEM      (rd_en_MEM),
        .wr_en_MEM      (wr_en_MEM),
        .addr_MEM       (addr_MEM),
        .wdata_MEM      (wdata_MEM),
        .kill_lane1     (kill_lane1),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .lane_rdata     (lane_rdata),
        .stall_MEM      (stall_MEM),
        .conflict_cnt   (conflict_cnt)
    );

    // Memory block: combinational read, write committed at the clock edge.
    assign mem_read_data = tb_mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            tb_mem[mem_address[9:2]] <= mem_write_data;
            wr_pulses <= wr_pulses + 1;
        end
    end

    function automatic int idx(input logic [W-1:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [W-1:0] a, input logic [W-1:0] v);
        tb_mem[idx(a)] <= v;
        ref_mem[idx(a)] = v;
    endtask

    task automatic idle_inputs();
        rd_en_MEM  = '0;
        wr_en_MEM  = '0;
        addr_MEM   = '0;
        wdata_MEM  = '0;
        kill_lane1 = 1'b0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_pair(
        input logic r0, input logic w0, input logic [W-1:0] a0, input logic [W-1:0] d0,
        input logic r1, input logic w1, input logic [W-1:0] a1, input logic [W-1:0] d1,
        input logic kill_idle, input logic kill_sec
    );
        logic act0, act1, conf;
        logic [W-1:0] exp0;
        int p0, exp_pulses;
        rd_en_MEM    = {r1, r0};
        wr_en_MEM    = {w1, w0};
        addr_MEM[0]  = a0;
        addr_MEM[1]  = a1;
        wdata_MEM[0] = d0;
        wdata_MEM[1] = d1;
        kill_lane1   = kill_idle;
        act0 = r0 | w0;
        act1 = (r1 | w1) & ~kill_idle;
        conf = act0 & act1;
        p0 = wr_pulses;
        exp_pulses = 0;
        @(negedge clk);
        if (!conf) begin
            check("stall_single", stall_MEM, 0);
            check("wen_single", mem_write_en, act0 ? w0 : (act1 ? w1 : 1'b0));
            check("ren_single", mem_read_en, act0 ? (r0 & ~w0) : (act1 ? (r1 & ~w1) : 1'b0));
            if (act0 | act1) check("addr_single", mem_address, act0 ? a0 : a1);
            else check("addr_none", mem_address, 0);
            if (act0 && w0) check("wdata_single", mem_write_data, d0);
            if (!act0 && act1 && w1) check("wdata_single", mem_write_data, d1);
            check("rdata0_single", lane_rdata[0], act0 ? ref_mem[idx(a0)] : '0);
            check("rdata1_single", lane_rdata[1], (!act0 && act1) ? ref_mem[idx(a1)] : '0);
            if (act0 && w0) begin
                ref_mem[idx(a0)] = d0;
                exp_pulses = 1;
            end else if (!act0 && act1 && w1) begin
                ref_mem[idx(a1)] = d1;
                exp_pulses = 1;
            end
            @(posedge clk); #1;
        end else begin
            check("stall_first", stall_MEM, 1);
            check("addr_first", mem_address, a0);
            check("wen_first", mem_write_en, w0);
            check("ren_first", mem_read_en, r0 & ~w0);
            if (w0) check("wdata_first", mem_write_data, d0);
            exp0 = ref_mem[idx(a0)];
            if (w0) begin
                ref_mem[idx(a0)] = d0;
                exp_pulses++;
            end
            ref_cnt++;
            @(posedge clk); #1;
            kill_lane1 = kill_sec;
            @(negedge clk);
            check("stall_second", stall_MEM, 0);
            check("rdata0_second", lane_rdata[0], exp0);
            if (kill_sec) begin
                check("wen_killed", mem_write_en, 0);
                check("ren_killed", mem_read_en, 0);
                check("rdata1_killed", lane_rdata[1], 0);
            end else begin
                check("addr_second", mem_address, a1);
                check("wen_second", mem_write_en, w1);
                check("ren_second", mem_read_en, r1 & ~w1);
                if (w1) check("wdata_second", mem_write_data, d1);
                check("rdata1_second", lane_rdata[1], ref_mem[idx(a1)]);
                if (w1) begin
                    ref_mem[idx(a1)] = d1;
                    exp_pulses++;
                end
            end
            @(posedge clk); #1;
        end
        check("write_pulses", wr_pulses - p0, exp_pulses);
        check("conflict_cnt", conflict_cnt, sat_cnt(ref_cnt));
        idle_inputs();
        txn++;
        $display("txn %0d: rd=%b wr=%b a0=%h a1=%h kill=%b%b conflict=%b cnt=%0d",
                 txn, {r1, r0}, {w1, w0}, a0, a1, kill_idle, kill_sec, conf, conflict_cnt);
    endtask

    initial begin
        logic [W-1:0] v;
        int p0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            tb_mem[i] <= v;
            ref_mem[i] = v;
        end
        // Reset with lanes requesting: every output must stay quiet.
        rst = 1'b0;
        idle_inputs();
        rd_en_MEM = 2'b11;
        wr_en_MEM = 2'b10;
        addr_MEM[0] = 32'h100;
        addr_MEM[1] = 32'h104;
        #2;
        check("rst_stall", stall_MEM, 0);
        check("rst_ren", mem_read_en, 0);
        check("rst_wen", mem_write_en, 0);
        check("rst_addr", mem_address, 0);
        check("rst_rdata", lane_rdata, 0);
        check("rst_cnt", conflict_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;

        // Single lane 0 load.
        poke(32'h100, 32'hDEADBEEF);
        run_pair(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        // Single lane 1 store.
        run_pair(0, 0, 0, 0, 0, 1, 32'h108, 32'h1234_5678, 0, 0);
        // Two loads conflict.
        poke(32'h100, 32'h11);
        poke(32'h104, 32'h22);
        run_pair(1, 0, 32'h100, 0, 1, 0, 32'h104, 0, 0, 0);
        // Store then load to the same address.
        run_pair(0, 1, 32'h200, 32'h55, 1, 0, 32'h200, 0, 0, 0);
        // Two stores to the same address, then read back.
        run_pair(0, 1, 32'h300, 32'hA, 0, 1, 32'h300, 32'hB, 0, 0);
        run_pair(1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        // Kill lane 1 during its serialized slot.
        run_pair(1, 0, 32'h100, 0, 0, 1, 32'h308, 32'hCAFE, 0, 1);
        run_pair(0, 0, 0, 0, 1, 0, 32'h308, 0, 0, 0);
        // Kill in IDLE: no conflict, no stall.
        run_pair(1, 1, 32'h30C, 32'h77, 1, 0, 32'h300, 0, 1, 0);

        // Reset while lane 1's store is pending.
        poke(32'h400, 32'h4000);
        poke(32'h404, 32'h4040);
        rd_en_MEM    = 2'b01;
        wr_en_MEM    = 2'b10;
        addr_MEM[0]  = 32'h400;
        addr_MEM[1]  = 32'h404;
        wdata_MEM[1] = 32'hBAD;
        p0 = wr_pulses;
        @(negedge clk);
        check("rst2_stall_before", stall_MEM, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst2_stall", stall_MEM, 0);
        check("rst2_ren", mem_read_en, 0);
        check("rst2_wen", mem_write_en, 0);
        check("rst2_addr", mem_address, 0);
        check("rst2_rdata", lane_rdata, 0);
        check("rst2_cnt", conflict_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        ref_cnt = 0;
        check("rst2_no_write", wr_pulses - p0, 0);
        run_pair(1, 0, 32'h404, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small address window to force collisions.
        for (int t = 0; t < 40; t++) begin
            run_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'h100 + 32'(4 * $urandom_range(0, 3)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'h100 + 32'(4 * $urandom_range(0, 3)), $urandom,
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Saturation of the conflict counter.
        for (int t = 0; t < (1 << CW) + 3; t++) begin
            run_pair(1, 0, 32'h100, 0, 1'($urandom_range(0, 1)), 1'b1,
                     32'h104 + 32'(4 * $urandom_range(0, 2)), $urandom, 0, 0);
        end
        check("cnt_saturated", conflict_cnt, CNT_MAX);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
